div_fifo_reader: RTL

// - Pop-side consumer of the divider request FIFO. Pops one request when idle and runs a

---
 rtl/div_fifo_reader.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/div_fifo_reader.sv
// div_fifo_reader: pops divide requests and runs a radix-2 restoring divider.
// Define DIV_FASTPATH_EN to retire trivial divides without iterating.
module div_fifo_reader #(
  parameter int XLEN     = 32,
  parameter int ID_WIDTH = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fifo_valid,
  input  logic [XLEN-1:0]     fifo_dividend,
  input  logic [XLEN-1:0]     fifo_divisor,
  input  logic                fifo_signed,
  input  logic                fifo_rem_op,
  input  logic [ID_WIDTH-1:0] fifo_id,
  output logic                fifo_pop,
  output logic                wb_valid,
  input  logic                wb_ack,
  output logic [XLEN-1:0]     wb_rd,
  output logic [ID_WIDTH-1:0] wb_id,
  output logic                busy
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [XLEN-1:0]     quo_q, quo_d;
  logic [XLEN-1:0]     dvs_q, dvs_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic                rop_q, rop_d;
  logic                negq_q, negq_d;
  logic                negr_q, negr_d;
  logic                dz_q, dz_d;
  logic                ovf_q, ovf_d;
  logic                wb_valid_q, wb_valid_d;
  logic [XLEN-1:0]     wb_rd_q, wb_rd_d;
  logic [ID_WIDTH-1:0] wb_id_q, wb_id_d;

  logic            sa, sb, dz_in, ovf_in, start;
  logic [XLEN-1:0] ma, mb, rem_n, quo_n;
  logic [XLEN:0]   trial;

  // Sign fixup plus the RISC-V M overrides for /0 and MIN/-1.
  function automatic logic [XLEN-1:0] pick(
    input logic            dz,
    input logic            ovf,
    input logic            nq,
    input logic            nr,
    input logic            rop,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] qm,
    input logic [XLEN-1:0] rm
  );
    logic [XLEN-1:0] q, r;
    q = nq ? -qm : qm;
    r = nr ? -rm : rm;
    if (dz) begin
      q = '1;
      r = a;
    end else if (ovf) begin
      q = MIN_NEG;
      r = '0;
    end
    return rop ? r : q;
  endfunction

  assign sa     = fifo_signed & fifo_dividend[XLEN-1];
  assign sb     = fifo_signed & fifo_divisor[XLEN-1];
  assign ma     = sa ? -fifo_dividend : fifo_dividend;
  assign mb     = sb ? -fifo_divisor : fifo_divisor;
  assign dz_in  = (fifo_divisor == '0);
  assign ovf_in = fifo_signed & (fifo_dividend == MIN_NEG)
                & (fifo_divisor == '1);

  // Shifted partial remainder needs one extra bit before the trial subtract.
  assign trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
  assign rem_n = trial[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]}
                             : trial[XLEN-1:0];
  assign quo_n = {quo_q[XLEN-2:0], ~trial[XLEN]};

`ifdef DIV_FASTPATH_EN
  logic fast;
  assign fast = dz_in | ovf_in | (mb > ma);
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    a_d        = a_q;
    id_d       = id_q;
    rop_d      = rop_q;
    negq_d     = negq_q;
    negr_d     = negr_q;
    dz_d       = dz_q;
    ovf_d      = ovf_q;
    wb_valid_d = wb_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_id_d    = wb_id_q;
    start      = 1'b0;

    unique case (state_q)
      IDLE: start = fifo_valid;
      BUSY: begin
        rem_d = rem_n;
        quo_d = quo_n;
        if (cnt_q == '0) begin
          state_d    = DONE;
          wb_valid_d = 1'b1;
          wb_id_d    = id_q;
          wb_rd_d    = pick(dz_q, ovf_q, negq_q, negr_q, rop_q,
                            a_q, quo_n, rem_n);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (wb_ack) begin
          wb_valid_d = 1'b0;
          state_d    = IDLE;
          start      = fifo_valid;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d = BUSY;
      cnt_d   = CW'(XLEN - 1);
      rem_d   = '0;
      quo_d   = ma;
      dvs_d   = mb;
      a_d     = fifo_dividend;
      id_d    = fifo_id;
      rop_d   = fifo_rem_op;
      negq_d  = fifo_signed & (sa ^ sb);
      negr_d  = sa;
      dz_d    = dz_in;
      ovf_d   = ovf_in;
`ifdef DIV_FASTPATH_EN
      if (fast) begin
        state_d    = DONE;
        wb_valid_d = 1'b1;
        wb_id_d    = fifo_id;
        wb_rd_d    = pick(dz_in, ovf_in, fifo_signed & (sa ^ sb), sa,
                          fifo_rem_op, fifo_dividend, '0, ma);
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      a_q        <= '0;
      id_q       <= '0;
      rop_q      <= 1'b0;
      negq_q     <= 1'b0;
      negr_q     <= 1'b0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_id_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      a_q        <= a_d;
      id_q       <= id_d;
      rop_q      <= rop_d;
      negq_q     <= negq_d;
      negr_q     <= negr_d;
      dz_q       <= dz_d;
      ovf_q      <= ovf_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_id_q    <= wb_id_d;
    end
  end

  assign fifo_pop = start;
  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_id    = wb_id_q;
  assign busy     = (state_q != IDLE);

endmodule
